// File: rtl/bcd_time_disp_scan.sv
// ---------------------------------------------------------------------------
// bcd_time_disp_scan
//
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// It takes the packed-BCD HH:MM word from the time counter and shows one
// digit at a time, SCAN_DIV clocks per digit. The time word is captured once
// per frame, at the end of the hours-tens slot, so a frame never mixes two
// different times. The colon is the hours-ones decimal point and blinks every
// BLINK_DIV clocks. An optional leading-zero blank darkens the hours-tens
// digit when it is 0. Any nibble above 9 is shown as a dash.
//
// Parameters
//   SCAN_DIV   clocks each digit is driven (>= 2)
//   BLINK_DIV  clocks per colon toggle (>= 2)
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous reset, active low
//   time_bcd  {H tens, H ones, M tens, M ones}; [3:0] = minutes ones
//   en        1 = display on, 0 = all digits dark (counters keep running)
//   blank_lz  1 = darken the hours-tens digit when it is 0
//   an        digit enables, active low; an[0] = minutes ones .. an[3] = hours tens
//   seg       segments, active low, {dp,g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module bcd_time_disp_scan #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] time_bcd,
    input  logic        en,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [7:0]  seg
);

    localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    // 7-segment decode of one BCD nibble, active low, {g,f,e,d,c,b,a}.
    // Non-BCD values light only segment g so the digit reads as "-".
    function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    // Select the nibble of the snapshot addressed by the scan index.
    function automatic logic [3:0] digit_select(input logic [15:0] word,
                                                input logic [1:0]  sel);
        logic [3:0] d;
        case (sel)
            2'd0:    d = word[3:0];
            2'd1:    d = word[7:4];
            2'd2:    d = word[11:8];
            default: d = word[15:12];
        endcase
        return d;
    endfunction

    logic [SCAN_W-1:0]  scan_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic [1:0]         idx;
    logic               colon_on;
    logic [15:0]        snap;

    logic               scan_wrap;
    logic               blink_wrap;
    logic               frame_end;

    assign scan_wrap  = (scan_cnt == SCAN_LAST);
    assign blink_wrap = (blink_cnt == BLINK_LAST);
    assign frame_end  = scan_wrap && (idx == 2'd3);

    // ---- stage p0: scan/blink timebase and per-frame snapshot ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt <= '0;
            idx      <= 2'd0;
        end else if (scan_wrap) begin
            scan_cnt <= '0;
            idx      <= idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    // Colon blink runs on its own counter, independent of the digit scan.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt <= '0;
            colon_on  <= 1'b0;
        end else if (blink_wrap) begin
            blink_cnt <= '0;
            colon_on  <= ~colon_on;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end

    // Capture on the same edge idx wraps 3->0, so the new time starts
    // exactly with digit 0 of the next frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap <= 16'h0000;
        end else if (frame_end) begin
            snap <= time_bcd;
        end
    end

    // ---- stage p0 -> p1: digit decode and enable masking ----
    logic [3:0] digit_p0;
    logic       dark_p0;
    logic       dp_n_p0;
    logic [3:0] an_p0;
    logic [7:0] seg_p0;

    always_comb begin
        digit_p0 = digit_select(snap, idx);
        // Whole display off, or leading hours-tens zero suppressed.
        dark_p0  = !en || ((idx == 2'd3) && blank_lz && (snap[15:12] == 4'd0));
        dp_n_p0  = !((idx == 2'd2) && colon_on);
        an_p0    = 4'hF;
        seg_p0   = 8'hFF;
        if (!dark_p0) begin
            an_p0  = ~(4'b0001 << idx);
            seg_p0 = {dp_n_p0, seg7_decode(digit_p0)};
        end
    end

    // ---- stage p1: registered pad drivers ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an  <= 4'hF;
            seg <= 8'hFF;
        end else begin
            an  <= an_p0;
            seg <= seg_p0;
        end
    end

endmodule

// File: tb/tb_bcd_time_disp_scan.sv
module tb_bcd_time_disp_scan;

    logic        clk;
    logic        rst;
    logic [15:0] time_bcd;
    logic        en;
    logic        blank_lz;
    logic [3:0]  an;
    logic [7:0]  seg;

    int n_tests = 0;
    int n_fail  = 0;
    int ecnt    = 0;   // rising edges since the last reset release

    bcd_time_disp_scan #(
        .SCAN_DIV (4),
        .BLINK_DIV(32)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .time_bcd(time_bcd),
        .en      (en),
        .blank_lz(blank_lz),
        .an      (an),
        .seg     (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %02h, expected %02h", tag, ecnt, got, exp);
        end
    endtask

    task automatic expect_disp(input string tag, input logic [3:0] exp_an, input logic [7:0] exp_seg);
        check_val({tag, ".an"},  {4'h0, an}, {4'h0, exp_an});
        check_val({tag, ".seg"}, seg, exp_seg);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ecnt++;
    endtask

    task automatic run_to(input int n);
        while (ecnt < n) tick();
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst  = 1'b1;
        ecnt = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst      = 1'b0;
        en       = 1'b1;
        blank_lz = 1'b0;
        time_bcd = 16'h2359;

        // Reset held across clock edges
        repeat (3) tick();
        expect_disp("rst_hold", 4'hF, 8'hFF);

        release_reset();
        tick();
        expect_disp("first_edge", 4'hE, 8'hC0);
        run_to(5);
        expect_disp("f1_d1", 4'hD, 8'hC0);
        run_to(9);
        expect_disp("f1_d2", 4'hB, 8'hC0);
        run_to(13);
        expect_disp("f1_d3", 4'h7, 8'hC0);

        // Frame 2 shows 23:59 (snap loaded at edge 16), colon still off
        run_to(17);
        expect_disp("snap_d0", 4'hE, 8'h90);
        run_to(21);
        expect_disp("snap_d1", 4'hD, 8'h92);
        run_to(25);
        expect_disp("snap_d2", 4'hB, 8'hB0);
        run_to(29);
        expect_disp("snap_d3", 4'h7, 8'hA4);

        // No tearing: 12:34 loads at edge 48, input drops to 00:00 in idx=1 slot
        run_to(32);
        time_bcd = 16'h1234;
        run_to(49);
        expect_disp("tear_d0", 4'hE, 8'h99);
        run_to(53);
        time_bcd = 16'h0000;
        tick();
        expect_disp("tear_d1", 4'hD, 8'hB0);
        run_to(57);
        expect_disp("tear_d2_colon", 4'hB, 8'h24);
        run_to(61);
        expect_disp("tear_d3", 4'h7, 8'hF9);
        run_to(65);
        expect_disp("zero_d0", 4'hE, 8'hC0);
        run_to(69);
        expect_disp("zero_d1", 4'hD, 8'hC0);
        run_to(73);
        expect_disp("zero_d2", 4'hB, 8'hC0);
        run_to(77);
        expect_disp("zero_d3", 4'h7, 8'hC0);

        // Leading-zero blank on 09:05
        run_to(80);
        time_bcd = 16'h0905;
        blank_lz = 1'b1;
        run_to(97);
        expect_disp("lz_d0", 4'hE, 8'h92);
        run_to(101);
        expect_disp("lz_d1", 4'hD, 8'hC0);
        run_to(105);
        expect_disp("lz_d2_colon", 4'hB, 8'h10);
        run_to(109);
        expect_disp("lz_d3_blank", 4'hF, 8'hFF);
        run_to(112);
        blank_lz = 1'b0;
        run_to(125);
        expect_disp("lz_off_d3", 4'h7, 8'hC0);

        // Invalid digit and colon blink period on 00:A0
        run_to(128);
        time_bcd = 16'h00A0;
        run_to(149);
        expect_disp("inv_d1", 4'hD, 8'hBF);
        run_to(153);
        expect_disp("blink_a", 4'hB, 8'hC0);
        run_to(157);
        expect_disp("inv_d3", 4'h7, 8'hC0);
        run_to(169);
        expect_disp("blink_b", 4'hB, 8'h40);
        run_to(217);
        expect_disp("blink_a64", 4'hB, 8'hC0);
        run_to(233);
        expect_disp("blink_b64", 4'hB, 8'h40);

        // en low for 10 cycles; scan position must carry on
        run_to(242);
        en = 1'b0;
        tick();
        expect_disp("en_off_first", 4'hF, 8'hFF);
        run_to(252);
        expect_disp("en_off_last", 4'hF, 8'hFF);
        en = 1'b1;
        tick();
        expect_disp("en_resume_d3", 4'h7, 8'hC0);
        run_to(257);
        expect_disp("en_resume_d0", 4'hE, 8'hC0);

        // Asynchronous reset mid-slot, no clock edge needed
        tick();
        #2;
        rst = 1'b0;
        #1;
        expect_disp("async_rst", 4'hF, 8'hFF);
        tick();
        expect_disp("async_rst_hold", 4'hF, 8'hFF);
        release_reset();
        tick();
        expect_disp("restart_d0", 4'hE, 8'hC0);
        run_to(5);
        expect_disp("restart_d1", 4'hD, 8'hC0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_time_disp_scan.md
# bcd_time_disp_scan

Time-multiplexed 4-digit, 7-segment display driver that consumes the 16-bit packed-BCD HH:MM word from the 24/60 clock counter and drives a common-anode board display. It sits directly downstream of the time counter. It snapshots the time once per scan frame so no digit tears mid-frame. It blinks the colon (the hours-ones decimal point), blanks an optional leading zero and flags non-BCD digits.

## Interface
- SCAN_DIV, 50000: clock cycles each digit is driven; must be ≥2.
- BLINK_DIV, 50000000: clock cycles per colon toggle; must be ≥2.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (low = reset).
- time_bcd  in  16  {H tens, H ones, M tens, M ones}, one BCD nibble each; [3:0] = minutes ones.
- en  in  1  1 = display on; 0 = all digits dark (counters keep running).
- blank_lz  in  1  1 = darken the hours-tens digit when its value is 0.
- an  out  4  digit enables, active-low; an[0] = minutes ones … an[3] = hours tens.
- seg  out  8  segments, active-low, {dp,g,f,e,d,c,b,a}.

## Operation
- scan_cnt counts 0..SCAN_DIV-1 and wraps. On the wrap edge, idx (2-bit) advances 0→1→2→3→0.
- snap (16-bit) loads time_bcd on the edge where scan_cnt==SCAN_DIV-1 and idx==3 (frame end).
  - A time_bcd change mid-frame takes effect only from the next frame.
- blink_cnt counts 0..BLINK_DIV-1. colon_on toggles on its wrap edge.
- Digit nibble = snap[4*idx+3 : 4*idx].
- Decode, with dp off:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex).
  - Nibble >9 gives BF (segment g only, shown as "-").
- dp: seg[7]=0 only when idx==2 and colon_on==1; otherwise 1.
- an = ~(1<<idx), with three exceptions:
  - an=1111 when en==0.
  - an=1111 when idx==3, blank_lz==1 and snap[15:12]==0.
  - seg=FF whenever an==1111.
- Reset (rst low, asynchronous): scan_cnt=0, idx=0, blink_cnt=0, colon_on=0, snap=0, an=1111, seg=FF.
  - Takes effect immediately, including mid-frame. All state restarts from the reset values.

## Timing
- an and seg are registered. The values at edge t+1 are computed from idx, snap, colon_on, en and blank_lz as they stood after edge t, which gives one cycle of latency.
- First edge after rst rises: an=1110, seg=C0 (snap=0).
- Each digit is driven for exactly SCAN_DIV cycles; a frame is 4×SCAN_DIV cycles.
- An idx change appears on an one edge later. A snap load at frame end is visible with digit 0 of the next frame, on that same one-edge lag.
- en and blank_lz changes affect an/seg on the next edge. en does not reset any counter.
- colon_on toggles every BLINK_DIV cycles, independent of scan. The dp change shows on the next edge, if idx==2.
- There are no handshakes: time_bcd is sampled only at frame end and must be stable in the clk domain.

## Test plan
Benches run with SCAN_DIV=4, BLINK_DIV=32.
- **Reset:** hold rst=0 → an=1111, seg=FF.
  - Release → first edge an=1110, seg=C0.
  - Then an=1101, 1011, 0111 after 4, 8, 12 further edges.
- **Snapshot load:** time_bcd=2359 from reset; frame 2 must show:
  - an=1110/seg=90
  - an=1101/seg=92
  - an=1011/seg=B0 or 30 (per colon_on)
  - an=0111/seg=A4
- **No tearing:** change time_bcd 1234→0000 during frame slot idx=1 → rest of that frame still shows 1234 digits; the next frame shows C0 on all four digits (leading-zero blank off).
- **Leading-zero blank:** blank_lz=1, time_bcd=0905 → idx=3 slot an=1111, seg=FF; other digits 92, C0, 90(±dp).
  - blank_lz=0 → idx=3 slot an=0111, seg=C0.
- **Invalid digit and colon:** time_bcd=00A0 → idx=1 slot seg=BF.
  - Over 64+ cycles, idx=2 slot seg alternates C0/40 with a period of 64 cycles.
- **en and async reset:**
  - en=0 for 10 cycles → an=1111/seg=FF one edge after en falls. Scan position is unchanged on resume.
  - rst=0 mid-slot → an=1111/seg=FF with no clock edge. Release restarts at an=1110.
